// File: rtl/mgmt_mdio_scheduler.sv
// mgmt_mdio_scheduler: arbitrates the single mgmt0 MDIO transceiver between
// host register accesses and an autonomous BMSR link poller (host has priority).
// Optional build macro MGMT_MDIO_POLL_EXT_EN: each poll also reads POLL_EXT_REG
// right after BMSR and publishes it on poll_ext_status.
module mgmt_mdio_scheduler #(
  parameter int unsigned POLL_INTERVAL = 1875000,
  parameter logic [4:0]  POLL_PHY_ADDR = 5'h00,
  parameter logic [4:0]  POLL_EXT_REG  = 5'h11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  host_md_addr,
  input  logic [4:0]  host_reg_addr,
  input  logic [15:0] host_wr_data,
  input  logic        host_reg_wr,
  input  logic        host_reg_rd,
  output logic        host_busy,
  output logic [15:0] host_rd_data,
  output logic [4:0]  phy_md_addr,
  output logic [4:0]  phy_reg_addr,
  output logic [15:0] phy_wr_data,
  output logic        phy_reg_wr,
  output logic        phy_reg_rd,
  input  logic [15:0] phy_rd_data,
  input  logic        mgmt_busy,
  output logic        poll_link_up,
  output logic [15:0] poll_bmsr,
  output logic [15:0] poll_ext_status,
  output logic        poll_link_change
);

  localparam int unsigned TMR_W    = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_INTERVAL - 1);
  localparam logic [4:0]  BMSR_REG = 5'h01;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_SETTLE, ST_WAIT} state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             poll_pending, poll_pending_nxt;
  logic             sel_host, sel_host_nxt;
  logic             ext_phase, ext_phase_nxt;
  logic             host_is_wr, host_is_wr_nxt;
  logic [4:0]       host_md_q, host_md_q_nxt;
  logic [4:0]       host_reg_q, host_reg_q_nxt;
  logic [15:0]      host_data_q, host_data_q_nxt;

  logic             host_busy_nxt;
  logic [15:0]      host_rd_data_nxt;
  logic [4:0]       phy_md_addr_nxt;
  logic [4:0]       phy_reg_addr_nxt;
  logic [15:0]      phy_wr_data_nxt;
  logic             phy_reg_wr_nxt;
  logic             phy_reg_rd_nxt;
  logic             poll_link_up_nxt;
  logic [15:0]      poll_bmsr_nxt;
  logic [15:0]      poll_ext_status_nxt;
  logic             poll_link_change_nxt;

  // State and registered outputs; reset clears everything immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      timer            <= '0;
      poll_pending     <= 1'b0;
      sel_host         <= 1'b0;
      ext_phase        <= 1'b0;
      host_is_wr       <= 1'b0;
      host_md_q        <= '0;
      host_reg_q       <= '0;
      host_data_q      <= '0;
      host_busy        <= 1'b0;
      host_rd_data     <= '0;
      phy_md_addr      <= '0;
      phy_reg_addr     <= '0;
      phy_wr_data      <= '0;
      phy_reg_wr       <= 1'b0;
      phy_reg_rd       <= 1'b0;
      poll_link_up     <= 1'b0;
      poll_bmsr        <= '0;
      poll_ext_status  <= '0;
      poll_link_change <= 1'b0;
    end else begin
      state            <= state_nxt;
      timer            <= timer_nxt;
      poll_pending     <= poll_pending_nxt;
      sel_host         <= sel_host_nxt;
      ext_phase        <= ext_phase_nxt;
      host_is_wr       <= host_is_wr_nxt;
      host_md_q        <= host_md_q_nxt;
      host_reg_q       <= host_reg_q_nxt;
      host_data_q      <= host_data_q_nxt;
      host_busy        <= host_busy_nxt;
      host_rd_data     <= host_rd_data_nxt;
      phy_md_addr      <= phy_md_addr_nxt;
      phy_reg_addr     <= phy_reg_addr_nxt;
      phy_wr_data      <= phy_wr_data_nxt;
      phy_reg_wr       <= phy_reg_wr_nxt;
      phy_reg_rd       <= phy_reg_rd_nxt;
      poll_link_up     <= poll_link_up_nxt;
      poll_bmsr        <= poll_bmsr_nxt;
      poll_ext_status  <= poll_ext_status_nxt;
      poll_link_change <= poll_link_change_nxt;
    end
  end

  // Next-state: poll timer, host capture, arbitration FSM and completion updates
  always_comb begin
    state_nxt            = state;
    timer_nxt            = timer + TMR_W'(1);
    poll_pending_nxt     = poll_pending;
    sel_host_nxt         = sel_host;
    ext_phase_nxt        = ext_phase;
    host_is_wr_nxt       = host_is_wr;
    host_md_q_nxt        = host_md_q;
    host_reg_q_nxt       = host_reg_q;
    host_data_q_nxt      = host_data_q;
    host_busy_nxt        = host_busy;
    host_rd_data_nxt     = host_rd_data;
    phy_md_addr_nxt      = phy_md_addr;
    phy_reg_addr_nxt     = phy_reg_addr;
    phy_wr_data_nxt      = phy_wr_data;
    phy_reg_wr_nxt       = 1'b0;
    phy_reg_rd_nxt       = 1'b0;
    poll_link_up_nxt     = poll_link_up;
    poll_bmsr_nxt        = poll_bmsr;
    poll_ext_status_nxt  = poll_ext_status;
    poll_link_change_nxt = 1'b0;

    // Host request capture; a strobe while busy is dropped, rd+wr counts as write
    if ((host_reg_rd || host_reg_wr) && !host_busy) begin
      host_busy_nxt   = 1'b1;
      host_is_wr_nxt  = host_reg_wr;
      host_md_q_nxt   = host_md_addr;
      host_reg_q_nxt  = host_reg_addr;
      host_data_q_nxt = host_wr_data;
    end

    unique case (state)
      ST_IDLE: begin
        if (!mgmt_busy) begin
          if (host_busy) begin
            sel_host_nxt     = 1'b1;
            ext_phase_nxt    = 1'b0;
            phy_md_addr_nxt  = host_md_q;
            phy_reg_addr_nxt = host_reg_q;
            phy_wr_data_nxt  = host_data_q;
            phy_reg_wr_nxt   = host_is_wr;
            phy_reg_rd_nxt   = !host_is_wr;
            state_nxt        = ST_ISSUE;
          end else if (poll_pending) begin
            sel_host_nxt     = 1'b0;
            ext_phase_nxt    = 1'b0;
            phy_md_addr_nxt  = POLL_PHY_ADDR;
            phy_reg_addr_nxt = BMSR_REG;
            phy_wr_data_nxt  = '0;
            phy_reg_rd_nxt   = 1'b1;
            state_nxt        = ST_ISSUE;
          end
        end
      end
      ST_ISSUE:  state_nxt = ST_SETTLE;
      // Transceiver raises mgmt_busy a cycle after the strobe, so ignore it here
      ST_SETTLE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!mgmt_busy) begin
          state_nxt = ST_IDLE;
          if (sel_host) begin
            if (!host_is_wr) host_rd_data_nxt = phy_rd_data;
            host_busy_nxt = 1'b0;
          end else if (!ext_phase) begin
            poll_bmsr_nxt        = phy_rd_data;
            poll_link_up_nxt     = phy_rd_data[2];
            poll_link_change_nxt = phy_rd_data[2] ^ poll_link_up;
`ifdef MGMT_MDIO_POLL_EXT_EN
            ext_phase_nxt        = 1'b1;
            phy_reg_addr_nxt     = POLL_EXT_REG;
            phy_reg_rd_nxt       = 1'b1;
            state_nxt            = ST_ISSUE;
`else
            poll_pending_nxt     = 1'b0;
`endif
          end else begin
`ifdef MGMT_MDIO_POLL_EXT_EN
            poll_ext_status_nxt = phy_rd_data;
`endif
            ext_phase_nxt    = 1'b0;
            poll_pending_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Interval timer wrap requests a poll; an already pending poll just stays pending
    if (timer == TMR_LAST) begin
      timer_nxt        = '0;
      poll_pending_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_mgmt_mdio_scheduler.sv
// Bench for mgmt_mdio_scheduler: transceiver model, strobe monitor and an
// expected-transaction scoreboard driven by a linear directed sequence.
module tb_mgmt_mdio_scheduler;

  localparam int unsigned INTERVAL = 100;
`ifdef MGMT_MDIO_POLL_EXT_EN
  localparam int unsigned POLL_TXNS = 2;
`else
  localparam int unsigned POLL_TXNS = 1;
`endif

  typedef struct {
    logic [4:0]  md;
    logic [4:0]  ra;
    logic        rd;
    logic        wr;
    logic [15:0] wd;
    logic        busy;
    int unsigned cyc;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  host_md_addr, host_reg_addr;
  logic [15:0] host_wr_data;
  logic        host_reg_wr, host_reg_rd;
  logic        host_busy;
  logic [15:0] host_rd_data;
  logic [4:0]  phy_md_addr, phy_reg_addr;
  logic [15:0] phy_wr_data;
  logic        phy_reg_wr, phy_reg_rd;
  logic [15:0] phy_rd_data = 16'h0;
  logic        mgmt_busy = 1'b0;
  logic        poll_link_up;
  logic [15:0] poll_bmsr, poll_ext_status;
  logic        poll_link_change;

  always #5 clk = ~clk;

  mgmt_mdio_scheduler #(
    .POLL_INTERVAL(INTERVAL),
    .POLL_PHY_ADDR(5'h00),
    .POLL_EXT_REG (5'h11)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .host_md_addr    (host_md_addr),
    .host_reg_addr   (host_reg_addr),
    .host_wr_data    (host_wr_data),
    .host_reg_wr     (host_reg_wr),
    .host_reg_rd     (host_reg_rd),
    .host_busy       (host_busy),
    .host_rd_data    (host_rd_data),
    .phy_md_addr     (phy_md_addr),
    .phy_reg_addr    (phy_reg_addr),
    .phy_wr_data     (phy_wr_data),
    .phy_reg_wr      (phy_reg_wr),
    .phy_reg_rd      (phy_reg_rd),
    .phy_rd_data     (phy_rd_data),
    .mgmt_busy       (mgmt_busy),
    .poll_link_up    (poll_link_up),
    .poll_bmsr       (poll_bmsr),
    .poll_ext_status (poll_ext_status),
    .poll_link_change(poll_link_change)
  );

  // Transceiver model: busy one cycle after a strobe, for busy_len cycles
  int unsigned busy_len = 10;
  int unsigned busy_cnt = 0;
  logic [15:0] host_val = 16'h0;
  logic [15:0] bmsr_val = 16'h0;
  logic [15:0] ext_val  = 16'h0;

  always @(posedge clk) begin
    if (phy_reg_rd || phy_reg_wr) begin
      mgmt_busy <= 1'b1;
      busy_cnt  <= busy_len;
      if (phy_reg_rd)
        phy_rd_data <= (phy_reg_addr == 5'h01) ? bmsr_val :
                       (phy_reg_addr == 5'h11) ? ext_val  : host_val;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else if (busy_cnt == 1) begin
      busy_cnt  <= 0;
      mgmt_busy <= 1'b0;
    end
  end

  // Monitor: log every strobe cycle and count link-change pulse cycles
  int unsigned cyc = 0;
  int unsigned chg_cnt = 0;
  txn_t obs_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (phy_reg_rd || phy_reg_wr)
      obs_log.push_back('{phy_md_addr, phy_reg_addr, phy_reg_rd, phy_reg_wr,
                          phy_wr_data, mgmt_busy, cyc});
    if (poll_link_change) chg_cnt <= chg_cnt + 1;
  end

  // Scoreboard state
  txn_t        exp_q[$];
  int unsigned rd_ptr = 0;
  int          n_asserts = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_asserts++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
    end
  endtask

  task automatic expect_txn(input logic [4:0] md, input logic [4:0] ra,
                            input logic wr, input logic [15:0] wd);
    exp_q.push_back('{md, ra, !wr, wr, wd, 1'b0, 0});
  endtask

  task automatic expect_poll();
    expect_txn(5'h00, 5'h01, 1'b0, 16'h0);
`ifdef MGMT_MDIO_POLL_EXT_EN
    expect_txn(5'h00, 5'h11, 1'b0, 16'h0);
`endif
  endtask

  // Pop each expected transaction and compare against the next observed strobe
  task automatic drain(input int unsigned budget);
    txn_t e, o;
    int unsigned waited;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      waited = 0;
      while (obs_log.size() <= rd_ptr && waited < budget) begin
        @(negedge clk);
        waited++;
      end
      if (obs_log.size() <= rd_ptr) begin
        chk("txn_timeout", 32'(obs_log.size()), 32'(rd_ptr + 1));
        exp_q.delete();
        break;
      end
      o = obs_log[rd_ptr];
      rd_ptr++;
      chk("txn_md_addr", 32'(o.md), 32'(e.md));
      chk("txn_reg_addr", 32'(o.ra), 32'(e.ra));
      chk("txn_dir", 32'({o.rd, o.wr}), 32'({e.rd, e.wr}));
      chk("txn_wr_data", 32'(o.wd), 32'(e.wd));
      chk("txn_issued_while_busy", 32'(o.busy), 32'(1'b0));
    end
  endtask

  task automatic check_no_extra(input string tag);
    chk(tag, 32'(obs_log.size()), 32'(rd_ptr));
  endtask

  task automatic host_req(input logic [4:0] md, input logic [4:0] ra,
                          input logic wr, input logic [15:0] wd);
    @(negedge clk);
    host_md_addr  = md;
    host_reg_addr = ra;
    host_wr_data  = wd;
    host_reg_wr   = wr;
    host_reg_rd   = !wr;
    @(negedge clk);
    host_reg_wr   = 1'b0;
    host_reg_rd   = 1'b0;
  endtask

  task automatic wait_host_idle(input int unsigned budget);
    int unsigned waited = 0;
    while (host_busy && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    chk("host_busy_timeout", 32'(host_busy), 32'(1'b0));
  endtask

  task automatic wait_model_idle();
    int unsigned waited = 0;
    while (mgmt_busy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
  endtask

  // Reset ends on a falling edge; the next rising edge is edge 1 of the timer
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int unsigned chg0, c1, c2;

  initial begin
    rst = 1'b1;
    host_md_addr = '0; host_reg_addr = '0; host_wr_data = '0;
    host_reg_wr = 1'b0; host_reg_rd = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_host_busy", 32'(host_busy), 32'(0));
    chk("rst_host_rd_data", 32'(host_rd_data), 32'(0));
    chk("rst_phy_strobes", 32'({phy_reg_rd, phy_reg_wr}), 32'(0));
    chk("rst_phy_addr", 32'({phy_md_addr, phy_reg_addr}), 32'(0));
    chk("rst_poll_link", 32'({poll_link_up, poll_link_change}), 32'(0));
    chk("rst_poll_bmsr", 32'(poll_bmsr), 32'(0));
    chk("rst_poll_ext", 32'(poll_ext_status), 32'(0));
    rst = 1'b0;

    // Host read with long busy, then a write that must leave host_rd_data alone
    do_reset();
    busy_len = 40; host_val = 16'h0141; bmsr_val = 16'h796D; ext_val = 16'hAC02;
    expect_txn(5'd1, 5'd2, 1'b0, 16'h0);
    host_req(5'd1, 5'd2, 1'b0, 16'h0);
    chk("host_busy_after_strobe", 32'(host_busy), 32'(1));
    wait_host_idle(200);
    chk("host_rd_data_read", 32'(host_rd_data), 32'(16'h0141));
    busy_len = 10;
    expect_txn(5'd3, 5'd4, 1'b1, 16'hA5A5);
    host_req(5'd3, 5'd4, 1'b1, 16'hA5A5);
    wait_host_idle(100);
    chk("host_rd_data_after_write", 32'(host_rd_data), 32'(16'h0141));
    drain(50);
    check_no_extra("host_phase_extra_strobe");
    chk("poll_bmsr_untouched_by_host", 32'(poll_bmsr), 32'(0));

    // Periodic poll: link up, then link down, then steady
    do_reset();
    chg0 = chg_cnt;
    expect_poll();
    repeat (150) @(negedge clk);
    drain(50);
    c1 = obs_log[rd_ptr - POLL_TXNS].cyc;
    chk("poll1_link_up", 32'(poll_link_up), 32'(1));
    chk("poll1_bmsr", 32'(poll_bmsr), 32'(16'h796D));
    chk("poll1_change_pulses", 32'(chg_cnt - chg0), 32'(1));
    chk("poll_no_host_rd_data", 32'(host_rd_data), 32'(0));
`ifdef MGMT_MDIO_POLL_EXT_EN
    chk("poll_ext_status", 32'(poll_ext_status), 32'(16'hAC02));
`else
    chk("poll_ext_status_zero", 32'(poll_ext_status), 32'(0));
`endif
    bmsr_val = 16'h7969;
    chg0 = chg_cnt;
    expect_poll();
    repeat (100) @(negedge clk);
    drain(50);
    c2 = obs_log[rd_ptr - POLL_TXNS].cyc;
    chk("poll_interval", c2 - c1, 32'(INTERVAL));
    chk("poll2_link_up", 32'(poll_link_up), 32'(0));
    chk("poll2_bmsr", 32'(poll_bmsr), 32'(16'h7969));
    chk("poll2_change_pulses", 32'(chg_cnt - chg0), 32'(1));
    chg0 = chg_cnt;
    expect_poll();
    repeat (100) @(negedge clk);
    drain(50);
    chk("poll3_change_pulses", 32'(chg_cnt - chg0), 32'(0));
    check_no_extra("poll_phase_extra_strobe");

    // Host strobe sampled on the same edge as the timer wrap (edge 100)
    wait_model_idle();
    do_reset();
    host_val = 16'h1234;
    repeat (INTERVAL - 1) @(posedge clk);
    expect_txn(5'd1, 5'd7, 1'b0, 16'h0);
    expect_poll();
    host_req(5'd1, 5'd7, 1'b0, 16'h0);
    repeat (70) @(negedge clk);
    drain(50);
    check_no_extra("collision_single_poll");
    chk("collision_host_rd_data", 32'(host_rd_data), 32'(16'h1234));
    chk("collision_poll_bmsr", 32'(poll_bmsr), 32'(16'h7969));

    // Second host strobe while busy is ignored
    wait_model_idle();
    do_reset();
    busy_len = 30; host_val = 16'hBEEF;
    expect_txn(5'd2, 5'd3, 1'b0, 16'h0);
    host_req(5'd2, 5'd3, 1'b0, 16'h0);
    repeat (3) @(negedge clk);
    host_req(5'd9, 5'd9, 1'b1, 16'h5555);
    wait_host_idle(200);
    repeat (5) @(negedge clk);
    drain(50);
    check_no_extra("ignored_strobe_extra");
    chk("ignored_host_rd_data", 32'(host_rd_data), 32'(16'hBEEF));

    // Reset during WAIT while the transceiver stays busy
    wait_model_idle();
    do_reset();
    busy_len = 40; host_val = 16'h0141;
    expect_txn(5'd1, 5'd2, 1'b0, 16'h0);
    host_req(5'd1, 5'd2, 1'b0, 16'h0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_host_busy", 32'(host_busy), 32'(0));
    chk("midrst_phy_addr", 32'({phy_md_addr, phy_reg_addr}), 32'(0));
    chk("midrst_phy_wr_data", 32'(phy_wr_data), 32'(0));
    drain(10);
    @(negedge clk);
    rst = 1'b0;
    host_val = 16'h0777; busy_len = 10;
    expect_txn(5'd4, 5'd6, 1'b0, 16'h0);
    host_req(5'd4, 5'd6, 1'b0, 16'h0);
    wait_host_idle(200);
    drain(20);
    check_no_extra("midrst_extra_strobe");
    chk("midrst_host_rd_data", 32'(host_rd_data), 32'(16'h0777));

    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
